// File: rtl/rca16_pkg.sv
// Shared types for the rca_16 stream stage: opcode encoding and the
// result record carried through the output FIFO.
package rca16_pkg;

    localparam int RCA_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ACC = 2'b01,
        OP_CLR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef struct packed {
        logic [RCA_W:0] sum;
        logic           ovf;
    } res_t;

endpackage

// File: rtl/rca16_res_fifo.sv
// Two-entry result FIFO. Head is read combinationally from the storage
// slot under the read pointer; a push and pop on a full FIFO overwrite the
// slot being popped, so ordering is preserved with the count unchanged.
module rca16_res_fifo
    import rca16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  res_t       din,
    input  logic       pop,
    output res_t       dout,
    output logic [1:0] cnt
);

    res_t mem [2];
    logic wr_ptr;
    logic rd_ptr;

    // Pointer and occupancy control; the only state cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents are meaningless while cnt says empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/rca16_stream_stage.sv
// Sequential wrapper that feeds an external combinational rca_16: one
// operand stage register, a 16-bit accumulator with sticky overflow, and a
// 2-entry result FIFO on the output stream.
module rca16_stream_stage
    import rca16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    // The external adder is exactly 16 bits and the FIFO is built for 2 entries.
    if (WIDTH != RCA_W || OUT_DEPTH != 2) begin : g_param_check
        $error("rca16_stream_stage supports only WIDTH=16 and OUT_DEPTH=2");
    end

    // Build a FIFO entry; ACC results carry the accumulator's sticky overflow.
    function automatic res_t make_entry(input op_e op, input logic [RCA_W:0] s,
                                        input logic sticky);
        res_t r;
        r.sum = s;
        r.ovf = (op == OP_ACC) ? (sticky | s[RCA_W]) : s[RCA_W];
        return r;
    endfunction

    logic             vld_p0;
    op_e              op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] acc;
    logic             acc_ovf;
    logic [1:0]       fifo_cnt;
    res_t             head;
    res_t             entry;
    logic             accept;
    logic             adv;
    logic             push;
    logic             pop;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign adv       = vld_p0 & ((op_p0 == OP_CLR) | (fifo_cnt < 2'd2) | pop);
    assign in_ready  = rst_n & (~vld_p0 | adv);
    assign accept    = in_valid & in_ready;
    assign push      = adv & (op_p0 != OP_CLR);
    assign entry     = make_entry(op_p0, add_s, acc_ovf);

    // Stage p0 boundary: valid flag tracks HOLD/IDLE of the operand register.
    always_ff @(posedge clk) begin
        if (!rst_n)      vld_p0 <= 1'b0;
        else if (accept) vld_p0 <= 1'b1;
        else if (adv)    vld_p0 <= 1'b0;
    end

    // Operand capture on accept; qualified by vld_p0 so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= op_e'(in_op);
            a_p0  <= in_a;
            b_p0  <= in_b;
        end
    end

    // Adder operand steering; ACC adds to the live accumulator, which is
    // already updated by a preceding ACC because that one advanced first.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (vld_p0) begin
            add_a = a_p0;
            case (op_p0)
                OP_ACC:  add_b = acc;
                OP_CLR:  add_b = '0;
                default: add_b = b_p0;
            endcase
        end
    end

    // Accumulator and sticky overflow, updated when the staged op advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (adv) begin
            if (op_p0 == OP_ACC) begin
                acc     <= add_s[WIDTH-1:0];
                acc_ovf <= acc_ovf | add_s[WIDTH];
            end else if (op_p0 == OP_CLR) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end
        end
    end

    // Output stage boundary: results queue here until the consumer pops.
    rca16_res_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .cnt   (fifo_cnt)
    );

    assign out_sum = out_valid ? head.sum : '0;
    assign out_ovf = out_valid ? head.ovf : 1'b0;

endmodule

// File: tb/tb_rca16_stream_stage.sv
// Bench for rca16_stream_stage: a behavioural stand-in for rca_16, a
// table of single-beat vectors, backpressure and reset sequences, and a
// randomized stream checked by an in-order reference scoreboard.
module tb_rca16_stream_stage;
    import rca16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [16:0] add_s;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the combinational rca_16 sitting next to the block.
    assign add_s = {1'b0, add_a} + {1'b0, add_b};

    rca16_stream_stage #(.WIDTH(16), .OUT_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted beat is applied in order to an
    // accumulator; results expected on the output are queued.
    typedef struct packed { logic [16:0] sum; logic ovf; } exp_t;
    exp_t        q[$];
    logic [15:0] m_acc;
    logic        m_ovf;

    always @(negedge clk) begin : scoreboard
        exp_t        e;
        logic [16:0] s;
        if (!rst_n) begin
            q.delete();
            m_acc = 16'h0;
            m_ovf = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", out_sum);
                end else begin
                    e = q.pop_front();
                    check("sb_sum", 32'(out_sum), 32'(e.sum));
                    check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
                end
            end
            if (in_valid && in_ready) begin
                if (in_op == 2'b01) begin
                    s = 17'(m_acc) + 17'(in_a);
                    q.push_back({s, m_ovf | s[16]});
                    m_ovf = m_ovf | s[16];
                    m_acc = s[15:0];
                end else if (in_op == 2'b10) begin
                    m_acc = 16'h0;
                    m_ovf = 1'b0;
                end else begin
                    s = 17'(in_a) + 17'(in_b);
                    q.push_back({s, s[16]});
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
        logic        ovf;
    } vec_t;

    vec_t vt[10];

    // Offer one beat for up to 'bound' cycles; called and returns at posedge+1.
    task automatic offer(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int bound, output bit taken);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        taken    = 1'b0;
        for (int c = 0; c < bound && !taken; c++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Single beat with empty FIFO and out_ready=1: check latency and result.
    task automatic run_vec(input vec_t v, input int idx);
        bit taken;
        int n;
        offer(v.op, v.a, v.b, 10, taken);
        check($sformatf("vec%0d_accept", idx), 32'(taken), 32'd1);
        if (v.op == 2'b10) begin
            @(negedge clk);
            check($sformatf("vec%0d_clr_noout", idx), 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            check($sformatf("vec%0d_latency", idx), 32'(n), 32'd2);
            check($sformatf("vec%0d_sum", idx), 32'(out_sum), 32'(v.sum));
            check($sformatf("vec%0d_ovf", idx), 32'(out_ovf), 32'(v.ovf));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit tk[4];
        bit taken;
        int op;

        vt[0] = '{2'b00, 16'h1234, 16'h0FFF, 17'h02233, 1'b0};
        vt[1] = '{2'b10, 16'h0000, 16'h0000, 17'h00000, 1'b0};
        vt[2] = '{2'b01, 16'hFFFF, 16'h1111, 17'h0FFFF, 1'b0};
        vt[3] = '{2'b01, 16'h0002, 16'h2222, 17'h10001, 1'b1};
        vt[4] = '{2'b00, 16'h0001, 16'h0002, 17'h00003, 1'b0};
        vt[5] = '{2'b00, 16'hFFFF, 16'h0001, 17'h10000, 1'b1};
        vt[6] = '{2'b11, 16'h8000, 16'h8000, 17'h10000, 1'b1};
        vt[7] = '{2'b01, 16'h0000, 16'h0000, 17'h00001, 1'b1};
        vt[8] = '{2'b10, 16'h0000, 16'h0000, 17'h00000, 1'b0};
        vt[9] = '{2'b01, 16'h0000, 16'h0000, 17'h00000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = 16'h0; in_b = 16'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Backpressure: two results in the FIFO plus one staged, fourth refused.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            offer(2'b00, 16'(16'h1000 * (i + 1)), 16'(i + 1), 4, tk[i]);
        check("bp_take0", 32'(tk[0]), 32'd1);
        check("bp_take1", 32'(tk[1]), 32'd1);
        check("bp_take2", 32'(tk[2]), 32'd1);
        check("bp_take3", 32'(tk[3]), 32'd0);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_sum", 32'(out_sum), 32'h01001);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_head_stable", 32'(out_sum), 32'h01001);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        offer(2'b00, 16'h4000, 16'h0004, 4, taken);
        check("bp_take3_retry", 32'(taken), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("bp_drained", 32'(q.size()), 32'd0);

        // Randomized full-rate stream.
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            op = int'($urandom_range(0, 3));
            if (op == 2) op = 1;
            in_op = 2'(op);
            in_a  = 16'($urandom);
            in_b  = 16'($urandom);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stream_drained", 32'(q.size()), 32'd0);

        // Reset with a full FIFO and an ACC staged.
        out_ready = 1'b0;
        offer(2'b00, 16'h0001, 16'h0001, 4, taken);
        offer(2'b00, 16'h0002, 16'h0002, 4, taken);
        offer(2'b01, 16'h0007, 16'h0000, 4, taken);
        check("rr_acc_staged", 32'(taken), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rr_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rr_out_valid", 32'(out_valid), 32'd0);
        check("rr_out_sum", 32'(out_sum), 32'd0);
        check("rr_out_ovf", 32'(out_ovf), 32'd0);
        check("rr_add_a", 32'(add_a), 32'd0);
        @(posedge clk);
        #1;
        run_vec('{2'b01, 16'h0005, 16'h0000, 17'h00005, 1'b0}, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
